vend_dispenser: RTL and testbench
=================================

// Module: vend_dispenser
// PURPOSE
// - Downstream end of the vending FSM output interface. It consumes the FSM's per-cycle
//   product strobe (out) and change code (change[1:0]), then drives the product and coin
//   ejection solenoids with timed pulses.
// - Decouples the single-cycle FSM outputs from slow mechanics using a small request FIFO.
//   Handles coin stock shortages: a 10-unit coin is substituted by two 5-unit coins.
// PARAMETERS
// - DEPTH      4   request FIFO entries (power of 2, >=2)
// - PULSE_CYC  4   clock cycles each solenoid stays asserted per ejection (>=1)
// - GAP_CYC    2   idle cycles after every pulse before the next action (>=1)
// PORTS
// - clk           in   1  system clock, all logic on rising edge
// - rst           in   1  synchronous reset, active-low (rst==0 resets on the clock edge)
// - vend_out      in   1  product strobe from vending FSM, 1 cycle per product
// - vend_change   in   2  change code: 00 none, 01 one 5-unit, 10 one 10-unit, 11 reserved
// - coin5_empty   in   1  5-unit coin tube empty (level)
// - coin10_empty  in   1  10-unit coin tube empty (level)
// - prod_sol      out  1  product solenoid drive (registered)
// - coin5_sol     out  1  5-unit coin solenoid drive (registered)
// - coin10_sol    out  1  10-unit coin solenoid drive (registered)
// - busy          out  1  FIFO non-empty or FSM not IDLE
// - overflow      out  1  sticky: request dropped because FIFO was full
// - fault         out  1  sticky: reserved code received, or a 5-unit coin owed with tube empty
// BEHAVIOUR
// - Reset: all outputs 0, FIFO empty, FSM in IDLE. A mid-pulse reset drops solenoids on
//   that edge and discards all queued requests.
// - Capture: every edge where vend_out|(vend_change!=0), push {vend_out,vend_change}.
//   There is no handshake; the FIFO is the only buffer.
// - Full FIFO + push + no pop in the same cycle: the request is dropped and overflow is set.
//   Full FIFO + push + pop in the same cycle: the push is accepted.
// - FSM states: IDLE, PULSE, GAP.
//   - IDLE with FIFO non-empty: pop the head into the cur register and build an action
//     list: product (if vend_out bit set), then coins.
//   - Coin plan: 01 -> C5. 10 -> C10 if !coin10_empty at pop, else C5,C5.
//     11 -> no coins, set fault.
//   - An all-empty list (not producible: FIFO only holds nonzero entries) returns to IDLE.
// - Starting an action: enter PULSE, load counter=PULSE_CYC-1, assert the matching solenoid.
//   - C5 action with coin5_empty=1 when starting: skip the pulse, set fault, take the next
//     action.
//   - PULSE: counter reaches 0 -> deassert the solenoid, enter GAP, counter=GAP_CYC-1.
//   - GAP: counter reaches 0 -> next action's PULSE, else IDLE.
// - Latency: request sampled at edge E0. The solenoid rises at edge E0+2 and stays high for
//   exactly PULSE_CYC cycles.
// - Exclusivity: at most one solenoid is high in any cycle. Solenoids never go high in IDLE
//   or GAP.
// - Back-to-back: IDLE may pop in the same cycle it is entered from GAP. The only idle cycle
//   between requests is the one IDLE cycle.
// - Counter width: $clog2(max(PULSE_CYC,GAP_CYC))+1. FIFO pointers carry an extra wrap bit
//   for the full/empty distinction.
// - overflow and fault clear only on reset.
// STRUCTURE
// - Shared package vend_pkg holds the change code constants (CHG_NONE, CHG_5, CHG_10,
//   CHG_RSVD) and the FSM state encoding. The vending FSM and its bench import the same
//   package.
// - One sub-module: vend_req_fifo, a DEPTH x 3 synchronous FIFO with push, pop, full, empty
//   and rd_data. It uses the same clk and rst.
// - The action sequencer and pulse/gap counter stay in this module.
// TESTING (PULSE_CYC=4, GAP_CYC=2, DEPTH=4)
// - Reset: hold rst=0 for 2 edges while vend_out=1 -> no solenoid, busy=0, overflow=0,
//   fault=0.
// - Product only: vend_out=1 for 1 cycle at E0 -> prod_sol high E0+2..E0+5, then busy
//   drops after the gap.
// - Product + change 10 with coins stocked: prod_sol 4 cycles, 2 idle, then coin10_sol
//   4 cycles. coin5_sol stays 0.
// - Change 10 with coin10_empty=1: coin5_sol pulses twice (4 high, 2 low, 4 high).
//   fault stays 0.
// - Change 01 with coin5_empty=1: no pulse, fault=1. A following product request is still
//   dispensed.
// - Overflow: 6 consecutive vend_out cycles -> 4 queued plus 1 in service, 1 dropped,
//   overflow=1. Exactly 5 prod_sol pulses.

Source files
------------

// File: rtl/vend_pkg.sv
// Shared definitions for the vending FSM and its dispenser back end:
// change codes, dispenser state encoding and the coin/product action plan.
package vend_pkg;

  localparam logic [1:0] CHG_NONE = 2'b00;
  localparam logic [1:0] CHG_5    = 2'b01;
  localparam logic [1:0] CHG_10   = 2'b10;
  localparam logic [1:0] CHG_RSVD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    ACT_NONE = 2'd0,
    ACT_PROD = 2'd1,
    ACT_C5   = 2'd2,
    ACT_C10  = 2'd3
  } act_t;

  // Remaining work for the request in service, taken in the order prod, c10, c5.
  typedef struct packed {
    logic       prod;
    logic       c10;
    logic [1:0] c5;
  } plan_t;

  // A 10-unit coin owed while the 10-unit tube is empty is paid as two 5-unit coins.
  // The reserved code yields no coins; the caller flags it.
  function automatic plan_t build_plan(input logic prod, input logic [1:0] chg,
                                       input logic coin10_empty);
    plan_t p;
    p.prod = prod;
    p.c10  = 1'b0;
    p.c5   = 2'd0;
    case (chg)
      CHG_5:   p.c5 = 2'd1;
      CHG_10: begin
        if (coin10_empty) p.c5  = 2'd2;
        else              p.c10 = 1'b1;
      end
      default: ;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/vend_req_fifo.sv
// Request queue between the single-cycle FSM strobes and the slow dispenser.
// A push while full is only taken when a pop frees a slot in the same cycle.
module vend_req_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rd_data = mem[rd_ptr[AW-1:0]];

  // Pointer update; the extra top bit separates full from empty.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/vend_dispenser.sv
// Dispenser back end: queues product/change requests and plays them out as
// timed solenoid pulses, one solenoid at a time.
//
//  state    | meaning
//  ---------+-----------------------------------------------------------
//  ST_IDLE  | nothing in service; pops the queue head when available
//  ST_PULSE | current action's solenoid is being driven
//  ST_GAP   | mechanical settle time before the next action or IDLE
//
// Solenoid outputs are a registered decode of the state/action pair, so they
// trail the state by one cycle: a request strobed at edge E0 is popped at E0+1
// and its first solenoid rises at E0+2.
module vend_dispenser
  import vend_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int PULSE_CYC = 4,
  parameter int GAP_CYC   = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       vend_out,
  input  logic [1:0] vend_change,
  input  logic       coin5_empty,
  input  logic       coin10_empty,
  output logic       prod_sol,
  output logic       coin5_sol,
  output logic       coin10_sol,
  output logic       busy,
  output logic       overflow,
  output logic       fault
);

  localparam int CNT_MAX = (PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;
  localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(GAP_CYC - 1);

  state_t           state, state_nx;
  act_t             act, act_nx;
  plan_t            cur, cur_nx, src;
  logic [CNT_W-1:0] cnt, cnt_nx;

  logic       push, pop, full, empty, launch, fault_set, overflow_set;
  logic [2:0] rd_data;

  assign push         = vend_out | (vend_change != CHG_NONE);
  assign overflow_set = push & full & ~pop;
  assign busy         = ~empty | (state != ST_IDLE);

  vend_req_fifo #(.DEPTH(DEPTH), .WIDTH(3)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .pop     (pop),
    .wr_data ({vend_out, vend_change}),
    .rd_data (rd_data),
    .full    (full),
    .empty   (empty)
  );

  // Next state: pulse/gap timing, queue pop, and choosing the next action.
  always_comb begin
    state_nx  = state;
    act_nx    = act;
    cur_nx    = cur;
    cnt_nx    = cnt;
    src       = cur;
    pop       = 1'b0;
    launch    = 1'b0;
    fault_set = 1'b0;

    case (state)
      ST_IDLE: begin
        if (!empty) begin
          pop    = 1'b1;
          launch = 1'b1;
          src    = build_plan(rd_data[2], rd_data[1:0], coin10_empty);
          if (rd_data[1:0] == CHG_RSVD) fault_set = 1'b1;
        end
      end
      ST_PULSE: begin
        if (cnt == '0) begin
          state_nx = ST_GAP;
          act_nx   = ACT_NONE;
          cnt_nx   = GAP_LD;
        end else begin
          cnt_nx = cnt - CNT_W'(1);
        end
      end
      ST_GAP: begin
        if (cnt == '0) launch = 1'b1;
        else           cnt_nx = cnt - CNT_W'(1);
      end
      default: state_nx = ST_IDLE;
    endcase

    // Start the next pending action; 5-unit coins owed with an empty tube are
    // written off (all of them, since the tube level cannot change mid-cycle).
    if (launch) begin
      cur_nx   = src;
      state_nx = ST_IDLE;
      act_nx   = ACT_NONE;
      if (src.prod) begin
        cur_nx.prod = 1'b0;
        act_nx      = ACT_PROD;
        state_nx    = ST_PULSE;
        cnt_nx      = PULSE_LD;
      end else if (src.c10) begin
        cur_nx.c10 = 1'b0;
        act_nx     = ACT_C10;
        state_nx   = ST_PULSE;
        cnt_nx     = PULSE_LD;
      end else if (src.c5 != 2'd0) begin
        if (coin5_empty) begin
          cur_nx.c5 = 2'd0;
          fault_set = 1'b1;
        end else begin
          cur_nx.c5 = src.c5 - 2'd1;
          act_nx    = ACT_C5;
          state_nx  = ST_PULSE;
          cnt_nx    = PULSE_LD;
        end
      end
    end
  end

  // State, sticky flags and registered solenoid drive.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= ST_IDLE;
      act        <= ACT_NONE;
      cur        <= '0;
      cnt        <= '0;
      overflow   <= 1'b0;
      fault      <= 1'b0;
      prod_sol   <= 1'b0;
      coin5_sol  <= 1'b0;
      coin10_sol <= 1'b0;
    end else begin
      state      <= state_nx;
      act        <= act_nx;
      cur        <= cur_nx;
      cnt        <= cnt_nx;
      if (overflow_set) overflow <= 1'b1;
      if (fault_set)    fault    <= 1'b1;
      prod_sol   <= (state == ST_PULSE) && (act == ACT_PROD);
      coin5_sol  <= (state == ST_PULSE) && (act == ACT_C5);
      coin10_sol <= (state == ST_PULSE) && (act == ACT_C10);
    end
  end

endmodule

// File: tb/tb_vend_dispenser.sv
// Bench for vend_dispenser: requests are fed to a timing model that predicts
// every solenoid pulse (kind and rise cycle); a monitor matches observed pulses.
module tb_vend_dispenser;
  import vend_pkg::*;

  localparam int DEPTH     = 4;
  localparam int PULSE_CYC = 4;
  localparam int GAP_CYC   = 2;
  localparam int SLOT      = PULSE_CYC + GAP_CYC;
  localparam int K_PROD = 0, K_C5 = 1, K_C10 = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       vend_out = 1'b0;
  logic [1:0] vend_change = CHG_NONE;
  logic       coin5_empty = 1'b0;
  logic       coin10_empty = 1'b0;
  logic       prod_sol, coin5_sol, coin10_sol, busy, overflow, fault;

  vend_dispenser #(.DEPTH(DEPTH), .PULSE_CYC(PULSE_CYC), .GAP_CYC(GAP_CYC)) dut (
    .clk          (clk),
    .rst          (rst),
    .vend_out     (vend_out),
    .vend_change  (vend_change),
    .coin5_empty  (coin5_empty),
    .coin10_empty (coin10_empty),
    .prod_sol     (prod_sol),
    .coin5_sol    (coin5_sol),
    .coin10_sol   (coin10_sol),
    .busy         (busy),
    .overflow     (overflow),
    .fault        (fault)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int kind; int rise; } exp_t;
  exp_t exp_q[$];
  int   pops[$];
  int   next_free = 0;
  bit   m_overflow = 1'b0;
  bit   m_fault = 1'b0;
  int   n_checks = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Reference model: one request occupies the dispenser for one pulse+gap slot
  // per real ejection plus the single IDLE pop cycle; a request can be popped
  // no earlier than the edge after it was captured.
  task automatic model_push(input bit vo, input bit [1:0] ch, input int a);
    int occ;
    bit pop_now;
    int kinds[$];
    int pt;
    occ = 0;
    pop_now = 1'b0;
    while (pops.size() > 0 && pops[0] < a) void'(pops.pop_front());
    foreach (pops[i]) begin
      occ++;
      if (pops[i] == a) pop_now = 1'b1;
    end
    if (occ >= DEPTH && !pop_now) begin
      m_overflow = 1'b1;
      return;
    end
    if (vo) kinds.push_back(K_PROD);
    case (ch)
      2'd1: if (coin5_empty) m_fault = 1'b1; else kinds.push_back(K_C5);
      2'd2: begin
        if (!coin10_empty)    kinds.push_back(K_C10);
        else if (coin5_empty) m_fault = 1'b1;
        else begin
          kinds.push_back(K_C5);
          kinds.push_back(K_C5);
        end
      end
      2'd3: m_fault = 1'b1;
      default: ;
    endcase
    pt = (a + 1 > next_free) ? a + 1 : next_free;
    foreach (kinds[k]) exp_q.push_back('{kind: kinds[k], rise: pt + 1 + k * SLOT});
    next_free = pt + kinds.size() * SLOT + 1;
    pops.push_back(pt);
  endtask

  // Drive one cycle of FSM outputs; it is captured on the following edge.
  task automatic send(input bit vo, input bit [1:0] ch);
    @(negedge clk);
    vend_out    = vo;
    vend_change = ch;
    if (vo || ch != 2'd0) model_push(vo, ch, cyc + 1);
  endtask

  task automatic drain();
    int t;
    t = 0;
    send(1'b0, 2'd0);
    while ((exp_q.size() != 0 || busy) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk("drain_timeout", (t >= 3000), 0);
    chk("busy_idle", busy, 0);
    chk("overflow", overflow, m_overflow);
    chk("fault", fault, m_fault);
  endtask

  task automatic do_reset(input int edges);
    @(negedge clk);
    rst = 1'b0;
    vend_out = 1'b0;
    vend_change = CHG_NONE;
    exp_q.delete();
    pops.delete();
    next_free = 0;
    m_overflow = 1'b0;
    m_fault = 1'b0;
    repeat (edges) @(negedge clk);
    chk("rst_sols", {coin10_sol, coin5_sol, prod_sol}, 0);
    chk("rst_busy", busy, 0);
    chk("rst_flags", {overflow, fault}, 0);
    rst = 1'b1;
  endtask

  // Monitor: exclusivity, pulse kind/timing against the scoreboard, pulse width.
  logic [2:0] mon_prev = 3'b000;
  logic [2:0] mon_cur;
  int         mon_len = 0;
  int         mon_kind;
  exp_t       mon_e;
  always @(negedge clk) begin
    if (!rst) begin
      mon_prev = 3'b000;
      mon_len  = 0;
    end else begin
      mon_cur = {coin10_sol, coin5_sol, prod_sol};
      chk("exclusive", ($countones(mon_cur) > 1), 0);
      if (mon_cur != 3'b000 && mon_prev == 3'b000) begin
        mon_kind = mon_cur[0] ? K_PROD : (mon_cur[1] ? K_C5 : K_C10);
        mon_len  = 1;
        if (exp_q.size() == 0) begin
          chk("unexpected_pulse", mon_kind, 99);
        end else begin
          mon_e = exp_q.pop_front();
          chk("pulse_kind", mon_kind, mon_e.kind);
          chk("pulse_rise", cyc, mon_e.rise);
        end
      end else if (mon_cur != 3'b000) begin
        mon_len++;
      end else if (mon_prev != 3'b000) begin
        chk("pulse_width", mon_len, PULSE_CYC);
      end
      mon_prev = mon_cur;
    end
  end

  initial begin
    int n, r, t;
    bit vo;
    bit [1:0] ch;

    // Reset held for two edges with a product strobe present.
    vend_out = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_sols", {coin10_sol, coin5_sol, prod_sol}, 0);
    chk("reset_busy", busy, 0);
    chk("reset_overflow", overflow, 0);
    chk("reset_fault", fault, 0);
    vend_out = 1'b0;
    rst = 1'b1;

    // Directed cases.
    send(1'b1, CHG_NONE);                      drain();
    send(1'b1, CHG_10);                        drain();
    coin10_empty = 1'b1;
    send(1'b0, CHG_10);                        drain();
    chk("no_fault_c10_sub", fault, 0);
    coin10_empty = 1'b0;
    coin5_empty  = 1'b1;
    send(1'b0, CHG_5); send(1'b0, CHG_NONE); send(1'b1, CHG_NONE); drain();
    chk("fault_c5_empty", fault, 1);
    coin5_empty = 1'b0;
    do_reset(2);
    for (int i = 0; i < 6; i++) send(1'b1, CHG_NONE);
    drain();
    chk("overflow_burst", overflow, 1);
    send(1'b0, CHG_RSVD);                      drain();

    // Reset in the middle of a pulse.
    do_reset(2);
    send(1'b1, CHG_NONE);
    send(1'b0, CHG_NONE);
    t = 0;
    while (!prod_sol && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("midrst_started", prod_sol, 1);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("midrst_sol_drop", {coin10_sol, coin5_sol, prod_sol}, 0);
    chk("midrst_busy", busy, 0);
    do_reset(1);

    // Randomized phases; coin tube levels change only while idle.
    for (int p = 0; p < 16; p++) begin
      if ($urandom_range(0, 1) == 1) do_reset(2);
      coin5_empty  = ($urandom_range(0, 3) == 0);
      coin10_empty = ($urandom_range(0, 2) == 0);
      n = $urandom_range(4, 24);
      for (int i = 0; i < n; i++) begin
        r  = $urandom_range(0, 15);
        ch = (r < 6) ? 2'd0 : (r < 11) ? 2'd1 : (r < 15) ? 2'd2 : 2'd3;
        vo = ($urandom_range(0, 9) < 6);
        if ($urandom_range(0, 3) == 0) send(1'b0, 2'd0);
        else                           send(vo, ch);
      end
      drain();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

endmodule
